// File: rtl/riscv_mmio_pkg.sv
// rtl/riscv_mmio_pkg.sv - MMIO register offsets and TX_STAT bit layout for the data-memory responder
package riscv_mmio_pkg;

    localparam logic [7:0] MMIO_GPIO    = 8'h00;
    localparam logic [7:0] MMIO_TX_DATA = 8'h04;
    localparam logic [7:0] MMIO_TX_STAT = 8'h08;
    localparam logic [7:0] MMIO_CYCLE   = 8'h0C;

    localparam int STAT_EMPTY_BIT  = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_COUNT_LSB  = 8;

    function automatic logic [31:0] tx_stat_word(input logic [7:0] count, input logic ovf,
                                                 input logic full, input logic empty);
        logic [31:0] w_word;
        w_word = '0;
        w_word[STAT_COUNT_LSB +: 8] = count;
        w_word[STAT_OVF_BIT]        = ovf;
        w_word[STAT_FULL_BIT]       = full;
        w_word[STAT_EMPTY_BIT]      = empty;
        return w_word;
    endfunction

endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// rtl/data_mem_mmio_tx_fifo.sv - console TX byte FIFO with count/full/empty and sticky overflow
module tx_fifo
    import riscv_mmio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_push_tdata,
    input  logic       i_push_tvalid,
    output logic [7:0] o_pop_tdata,
    output logic       o_pop_tvalid,
    input  logic       i_pop_tready,
    input  logic       i_ovf_clr,
    output logic [7:0] o_count,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_pop_tready;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign w_push  = i_push_tvalid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push_tvalid && w_full && !w_pop) r_ovf <= 1'b1;
            else if (i_ovf_clr)                   r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_tdata;
    end

    assign o_pop_tdata  = r_mem[r_rd_ptr];
    assign o_pop_tvalid = !w_empty;
    assign o_count      = 8'(r_count);
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_ovf        = r_ovf;

endmodule

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - CPU data-memory responder: word RAM plus GPIO/TX/CYCLE MMIO
// Optional cycle counter enabled by defining DMEM_CYCLE_COUNTER_EN.
module data_mem_mmio
    import riscv_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAW = $clog2(RAM_WORDS);

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_gpio;

    logic [RAW-1:0] w_ram_idx;
    logic [7:0]     w_off;
    logic           w_is_mmio;
    logic           w_mmio_wr;
    logic           w_push;
    logic           w_ovf_clr;
    logic [7:0]     w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_ovf;
    logic [31:0]    w_cycle;
    logic [31:0]    w_read_data;
    logic           w_unused_addr;

    assign w_ram_idx = Mem_WrAddr[RAW+1:2];
    assign w_off     = Mem_WrAddr[7:0];
    assign w_is_mmio = Mem_WrAddr[31];
    assign w_mmio_wr = MemWrite && w_is_mmio;
    assign w_push    = w_mmio_wr && (w_off == MMIO_TX_DATA);
    assign w_ovf_clr = w_mmio_wr && (w_off == MMIO_TX_STAT) && Mem_WrData[STAT_OVF_BIT];

    // Byte-lane and upper MMIO address bits are intentionally don't-care.
    assign w_unused_addr = ^{Mem_WrAddr[1:0], Mem_WrAddr[30:8]};

    always_ff @(posedge clk) begin
        if (MemWrite && !w_is_mmio) r_ram[w_ram_idx] <= Mem_WrData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gpio <= '0;
        end else if (w_mmio_wr && (w_off == MMIO_GPIO)) begin
            r_gpio <= Mem_WrData;
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_mmio_wr && (w_off == MMIO_CYCLE)) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push_tdata  (Mem_WrData[7:0]),
        .i_push_tvalid (w_push),
        .o_pop_tdata   (tx_data),
        .o_pop_tvalid  (tx_valid),
        .i_pop_tready  (tx_ready),
        .i_ovf_clr     (w_ovf_clr),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_ovf         (w_ovf)
    );

    always_comb begin
        w_read_data = '0;
        if (!w_is_mmio) begin
            w_read_data = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                MMIO_GPIO:    w_read_data = r_gpio;
                MMIO_TX_STAT: w_read_data = tx_stat_word(w_count, w_ovf, w_full, w_empty);
                MMIO_CYCLE:   w_read_data = w_cycle;
                default:      w_read_data = '0;
            endcase
        end
    end

    assign ReadData = w_read_data;
    assign gpio_out = r_gpio;

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - randomized self-checking bench for data_mem_mmio against a queue-based model
module tb_data_mem_mmio;

    localparam int RAM_WORDS = 1024;
    localparam int TX_DEPTH  = 8;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_TXD  = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = '0;
    logic [31:0] Mem_WrData = '0;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    always #5 clk = ~clk;

    data_mem_mmio #(.RAM_WORDS(RAM_WORDS), .TX_DEPTH(TX_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadData   (ReadData),
        .gpio_out   (gpio_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_gpio = '0;
    logic [31:0] m_cycle = '0;
    logic [31:0] m_ram[int];

    function automatic logic [31:0] exp_stat();
        int n;
        n = m_q.size();
        return {16'b0, 8'(n), 5'b0, m_ovf, (n == TX_DEPTH), (n == 0)};
    endfunction

    function automatic int ram_key(input logic [31:0] a);
        return int'((a >> 2) % RAM_WORDS);
    endfunction

    // One clock: drive after the falling edge, apply the spec's rules to the model at the rising edge.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic rdy, input logic rst);
        int  n_before;
        bit  pop;
        bit  push;
        @(negedge clk);
        reset = rst; MemWrite = we; Mem_WrAddr = addr; Mem_WrData = data; tx_ready = rdy;
        @(posedge clk);
        n_before = m_q.size();
        pop  = (n_before > 0) && rdy;
        push = we && addr[31] && (addr[7:0] == 8'h04);
        if (we && !addr[31]) m_ram[ram_key(addr)] = data;
        if (rst) begin
            m_q.delete(); m_ovf = 1'b0; m_gpio = '0; m_cycle = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (n_before == TX_DEPTH && !pop) m_ovf = 1'b1;
                else m_q.push_back(data[7:0]);
            end
            if (we && addr[31] && addr[7:0] == 8'h08 && data[2]) m_ovf = 1'b0;
            if (we && addr[31] && addr[7:0] == 8'h00) m_gpio = data;
            if (we && addr[31] && addr[7:0] == 8'h0C) m_cycle = '0;
            else m_cycle = m_cycle + 32'd1;
        end
        #1;
        MemWrite = 1'b0; reset = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        MemWrite = 1'b0;
        Mem_WrAddr = a;
        #1;
        v = ReadData;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);
        n_checks++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 32'h0); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        rd(A_STAT, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL reset_stat got=%h exp=%h", v, 32'h1); end
    endtask

    task automatic test_ram();
        logic [31:0] v, a, a2;
        step(1, 32'h40, 32'hDEAD_BEEF, 0, 0);
        rd(32'h40, v);
        n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_0x40 got=%h exp=%h", v, 32'hDEAD_BEEF); end
        rd(32'h1040, v);
        n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias_0x1040 got=%h exp=%h", v, 32'hDEAD_BEEF); end
        rd(32'h42, v);
        n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_byte_0x42 got=%h exp=%h", v, 32'hDEAD_BEEF); end
        for (int i = 0; i < 24; i++) begin
            a = $urandom & 32'h7FFF_FFFF;
            step(1, a, $urandom, 0, 0);
            a2 = a ^ ($urandom & 32'h7FFF_F003);
            rd(a2, v);
            n_checks++; if (v !== m_ram[ram_key(a2)]) begin n_fail++; $display("FAIL ram_rand addr=%h got=%h exp=%h", a2, v, m_ram[ram_key(a2)]); end
        end
    endtask

    task automatic test_gpio();
        logic [31:0] v, a;
        step(1, A_GPIO, 32'hA5, 0, 0);
        n_checks++; if (gpio_out !== 32'hA5) begin n_fail++; $display("FAIL gpio_store got=%h exp=%h", gpio_out, 32'hA5); end
        rd(32'h8000_0010, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", v); end
        rd(A_TXD, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL txdata_read got=%h exp=0", v); end
        rd(A_GPIO, v);
        n_checks++; if (v !== 32'hA5) begin n_fail++; $display("FAIL gpio_read got=%h exp=%h", v, 32'hA5); end
        for (int i = 0; i < 8; i++) begin
            a = A_GPIO | ($urandom & 32'h7FFF_FF00);
            step(1, (i % 3 == 2) ? (a | 32'h10) : a, $urandom, 0, 0);
            n_checks++; if (gpio_out !== m_gpio) begin n_fail++; $display("FAIL gpio_rand got=%h exp=%h", gpio_out, m_gpio); end
        end
    endtask

    task automatic test_fifo_fill();
        logic [31:0] v;
        logic [7:0]  got[$];
        for (int i = 1; i <= 9; i++) step(1, A_TXD, 32'(i), 0, 0);
        rd(A_STAT, v);
        n_checks++; if (v !== 32'h0806) begin n_fail++; $display("FAIL fill_stat got=%h exp=%h", v, 32'h0806); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL drain_valid got=%b exp=%b", tx_valid, (m_q.size() != 0)); end
            if (tx_valid) got.push_back(tx_data);
            step(0, '0, '0, 1, 0);
        end
        n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL drain_len got=%0d exp=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_checks++; if (got[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got[i], 8'(i + 1)); end
        end
        rd(A_STAT, v);
        n_checks++; if (v !== 32'h0005) begin n_fail++; $display("FAIL drained_stat got=%h exp=%h", v, 32'h0005); end
    endtask

    task automatic test_edge();
        logic [31:0] v;
        for (int i = 0; i < TX_DEPTH; i++) step(1, A_TXD, $urandom, 0, 0);
        step(1, A_TXD, 32'hEE, 1, 0);
        rd(A_STAT, v);
        n_checks++; if (v[15:8] !== 8'd8 || v !== exp_stat()) begin n_fail++; $display("FAIL full_pushpop_stat got=%h exp=%h", v, exp_stat()); end
        n_checks++; if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL full_pushpop_head got=%h exp=%h", tx_data, m_q[0]); end
        step(1, A_STAT, 32'h3, 0, 0);
        rd(A_STAT, v);
        n_checks++; if (v[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_noclr got=%b exp=1", v[2]); end
        step(1, A_STAT, 32'h4, 0, 0);
        rd(A_STAT, v);
        n_checks++; if (v[2] !== 1'b0 || v !== exp_stat()) begin n_fail++; $display("FAIL ovf_clr got=%h exp=%h", v, exp_stat()); end
        for (int i = 0; i < 20 && m_q.size() != 0; i++) begin
            n_checks++; if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL edge_drain got=%h exp=%h", tx_data, m_q[0]); end
            step(0, '0, '0, 1, 0);
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL pre_push_valid got=%b exp=0", tx_valid); end
        step(1, A_TXD, 32'h3C, 0, 0);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin n_fail++; $display("FAIL first_word valid=%b data=%h exp=1/3c", tx_valid, tx_data); end
        step(0, '0, '0, 0, 0);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin n_fail++; $display("FAIL hold_stable valid=%b data=%h exp=1/3c", tx_valid, tx_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic        we, rdy;
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            we  = ($urandom_range(0, 9) < 7);
            a   = ($urandom_range(0, 9) < 8) ? A_TXD : A_STAT;
            rdy = ($urandom_range(0, 9) < 4);
            step(we, a, $urandom, rdy, 0);
            n_checks++; if (tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, tx_valid, (m_q.size() != 0)); end
            if (m_q.size() != 0) begin
                n_checks++; if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, tx_data, m_q[0]); end
            end
            rd(A_STAT, v);
            n_checks++; if (v !== exp_stat()) begin n_fail++; $display("FAIL b2b_stat cyc=%0d got=%h exp=%h", i, v, exp_stat()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        step(1, A_STAT, 32'h4, 1, 0);
        for (int i = 0; i < 30 && m_q.size() != 0; i++) step(0, '0, '0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, A_TXD, $urandom, 0, 0);
        step(1, A_GPIO, 32'h1234_5678, 0, 0);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", tx_valid); end
        step(0, '0, '0, 1, 1);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", tx_valid); end
        n_checks++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL mid_reset_gpio got=%h exp=0", gpio_out); end
        rd(A_STAT, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL mid_reset_stat got=%h exp=%h", v, 32'h1); end
    endtask

    task automatic test_cycle();
        logic [31:0] v;
`ifdef DMEM_CYCLE_COUNTER_EN
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, '0, '0, 0, 0);
        rd(A_CYC, v);
        n_checks++; if (v !== 32'd10 || v !== m_cycle) begin n_fail++; $display("FAIL cycle_10 got=%h exp=%h", v, 32'd10); end
        step(1, A_CYC, $urandom, 0, 0);
        rd(A_CYC, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL cycle_clear got=%h exp=0", v); end
        step(0, '0, '0, 0, 0);
        rd(A_CYC, v);
        n_checks++; if (v !== m_cycle) begin n_fail++; $display("FAIL cycle_count got=%h exp=%h", v, m_cycle); end
        force dut.r_cycle = 32'hFFFF_FFFF;
        rd(A_CYC, v);
        release dut.r_cycle;
        m_cycle = 32'hFFFF_FFFF;
        step(0, '0, '0, 0, 0);
        rd(A_CYC, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL cycle_wrap got=%h exp=0", v); end
`else
        rd(A_CYC, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL cycle_off got=%h exp=0", v); end
        step(1, A_CYC, 32'h55, 0, 0);
        step(0, '0, '0, 0, 0);
        rd(A_CYC, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL cycle_off_wr got=%h exp=0", v); end
`endif
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_fifo_fill();
        test_edge();
        test_back_to_back();
        test_reset_mid();
        test_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
